dw_conv_line_buf: RTL

- Upstream feeder for the depthwise-convolution window generator.
- Accepts a raster pixel stream: one pixel per beat, all `CH_NUM` channels in parallel.
- Keeps the two previous image rows in internal line buffers.
- Emits one 3-row vertical column per accepted pixel, the format the 3×3 window shifter consumes.
- Sits between the feature-map reader and the depthwise window generator in the DW conv pre-process path.

---
 rtl/dw_conv_line_buf_if.sv | 23 ++
 rtl/dw_conv_line_buf.sv | 86 ++++++++
 2 files changed

// File: rtl/dw_conv_line_buf_if.sv
// Pixel-in / column-out bus of the depthwise-conv line buffer.
// The master drives the pixels in. The slave is the line buffer, which drives the columns out.
interface dw_conv_line_buf_if #(
    parameter int CH_NUM     = 18,
    parameter int DATA_WIDTH = 8
);
    logic [CH_NUM*DATA_WIDTH-1:0]   data_in;
    logic                           valid_in;
    logic [CH_NUM*3*DATA_WIDTH-1:0] col_out;
    logic                           valid_out;
    logic                           col_last;
    logic                           frame_done;

    modport master (
        output data_in, valid_in,
        input  col_out, valid_out, col_last, frame_done
    );

    modport slave (
        input  data_in, valid_in,
        output col_out, valid_out, col_last, frame_done
    );
endinterface

// File: rtl/dw_conv_line_buf.sv
// Two-row line buffer that emits a 3-row column per pixel; DWLB_ZERO_PAD_EN adds top zero padding.
// Latency 1 cycle: the outputs are registered and appear the cycle after the accepting edge.
// No backpressure: every valid_in beat is accepted. Idle beats freeze all state.
module dw_conv_line_buf #(
    parameter int CH_NUM     = 18,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic               clk,
    input  logic               rst,
    dw_conv_line_buf_if.slave  bus
);
    localparam int PIX_W = CH_NUM * DATA_WIDTH;
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
`ifdef DWLB_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic {FILL, STREAM} state_t;

    state_t              state;
    logic [XW-1:0]       x_cnt;
    logic [YW-1:0]       y_cnt;
    logic [PIX_W-1:0]    lb1 [IMG_WIDTH];
    logic [PIX_W-1:0]    lb2 [IMG_WIDTH];
    logic [PIX_W-1:0]    top_pix, mid_pix;
    logic [3*PIX_W-1:0]  col_nxt;
    logic                row_end, frame_end, emit;

    always_comb begin
        row_end   = (x_cnt == XW'(IMG_WIDTH - 1));
        frame_end = row_end && (y_cnt == YW'(IMG_HEIGHT - 1));
        emit      = PAD_EN || (state == STREAM);
        // Masking keyed on y_cnt keeps stale rows from a previous frame or a reset off the output.
        top_pix   = (PAD_EN && (y_cnt < YW'(2))) ? '0 : lb2[x_cnt];
        mid_pix   = (PAD_EN && (y_cnt == '0))    ? '0 : lb1[x_cnt];
        col_nxt   = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            col_nxt[(j*3+0)*DATA_WIDTH +: DATA_WIDTH] = top_pix[j*DATA_WIDTH +: DATA_WIDTH];
            col_nxt[(j*3+1)*DATA_WIDTH +: DATA_WIDTH] = mid_pix[j*DATA_WIDTH +: DATA_WIDTH];
            col_nxt[(j*3+2)*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The buffers have no reset, so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && bus.valid_in) begin
            lb2[x_cnt] <= lb1[x_cnt];
            lb1[x_cnt] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL;
            x_cnt          <= '0;
            y_cnt          <= '0;
            bus.col_out    <= '0;
            bus.valid_out  <= 1'b0;
            bus.col_last   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else if (bus.valid_in) begin
            x_cnt <= row_end ? '0 : x_cnt + XW'(1);
            if (row_end)
                y_cnt <= frame_end ? '0 : y_cnt + YW'(1);
            case (state)
                FILL:    if (row_end && (y_cnt == YW'(1))) state <= STREAM;
                STREAM:  if (frame_end) state <= FILL;
                default: state <= FILL;
            endcase
            bus.valid_out  <= emit;
            bus.col_last   <= emit && row_end;
            bus.frame_done <= emit && frame_end;
            if (emit)
                bus.col_out <= col_nxt;
        end else begin
            bus.valid_out  <= 1'b0;
            bus.col_last   <= 1'b0;
            bus.frame_done <= 1'b0;
        end
    end
endmodule
